nibble_compare_sequencer: RTL and testbench

NIBBLE_COMPARE_SEQUENCER -- requirements
Module: nibble_compare_sequencer

---
 rtl/nibble_compare_sequencer.sv | 110 +++++++++++
 tb/tb_nibble_compare_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_compare_sequencer.sv
// Unsigned magnitude compare of two NIBBLES*4-bit operands, one nibble
// per cycle MSB-first, using an external 4-bit comparator slice.
module nibble_compare_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  output logic [3:0]           cmp_a,
  output logic [3:0]           cmp_b,
  input  logic                 cmp_gt,
  input  logic                 cmp_lt,
  input  logic                 cmp_eq,
  output logic                 busy,
  output logic                 done,
  output logic                 a_gt_b,
  output logic                 a_lt_b,
  output logic                 a_eq_b
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [2:0]      res_q, res_d;
  logic [W-1:0]    a_sh, b_sh;

  // Sequencing relies on gt/lt alone; equality is implied by neither.
  logic unused_cmp_eq;
  assign unused_cmp_eq = cmp_eq;

  assign a_sh = a_q >> {idx_q, 2'b00};
  assign b_sh = b_q >> {idx_q, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cmp_a   = '0;
    cmp_b   = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          idx_d   = IW'(NIBBLES - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        cmp_a = a_sh[3:0];
        cmp_b = b_sh[3:0];
        if (cmp_gt) begin
          res_d   = 3'b100;
          state_d = DONE;
        end else if (cmp_lt) begin
          res_d   = 3'b010;
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_d   = 3'b001;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign a_gt_b = res_q[2];
  assign a_lt_b = res_q[1];
  assign a_eq_b = res_q[0];

endmodule

// File: tb/tb_nibble_compare_sequencer.sv
// Scoreboard bench for nibble_compare_sequencer: stimulus pushes expected
// results, a negedge monitor pops and checks them on every done pulse.
module tb_nibble_compare_sequencer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        force_both;
  logic [15:0] op_a, op_b;
  logic [3:0]  cmp_a, cmp_b;
  logic        cmp_gt, cmp_lt, cmp_eq;
  logic        busy, done;
  logic        a_gt_b, a_lt_b, a_eq_b;

  always #5 clk = ~clk;

  // External comparator slice; force_both injects inconsistent flags.
  assign cmp_gt = force_both | (cmp_a > cmp_b);
  assign cmp_lt = force_both | (cmp_a < cmp_b);
  assign cmp_eq = ~force_both & (cmp_a == cmp_b);

  nibble_compare_sequencer #(.NIBBLES(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .cmp_a  (cmp_a),
    .cmp_b  (cmp_b),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .cmp_eq (cmp_eq),
    .busy   (busy),
    .done   (done),
    .a_gt_b (a_gt_b),
    .a_lt_b (a_lt_b),
    .a_eq_b (a_eq_b)
  );

  typedef struct {
    logic [2:0] res;
    int         due;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output int k, output logic [2:0] r);
    logic [3:0] na, nb;
    k = N;
    r = 3'b001;
    for (int i = N - 1; i >= 0; i--) begin
      na = a[4*i +: 4];
      nb = b[4*i +: 4];
      if (na != nb) begin
        k = N - i;
        r = (na > nb) ? 3'b100 : 3'b010;
        break;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one sample edge at cycle t0 and queues the expectation.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input bit inj, output int t0, output int k);
    logic [2:0] r;
    step();
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    t0    = cyc;
    if (inj) begin
      k = 1;
      r = 3'b100;
    end else begin
      model(a, b, k, r);
    end
    q.push_back('{r, t0 + k + 1});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && cyc > q[0].due) begin
      tests++;
      fails++;
      $display("FAIL done_missing: got none expected done at cycle %0d",
               q[0].due);
      void'(q.pop_front());
    end
    if (done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done expected none (cycle %0d)",
                 cyc);
      end else begin
        e = q.pop_front();
        check("done_cycle", cyc, e.due);
        check("result", {a_gt_b, a_lt_b, a_eq_b}, e.res);
        check("onehot", $countones({a_gt_b, a_lt_b, a_eq_b}), 1);
        check("busy_in_done", busy, 1);
      end
    end
  end

  initial begin
    int t0, k;
    logic [15:0] ra, rb;
    rst        = 1'b1;
    start      = 1'b0;
    force_both = 1'b0;
    op_a       = '0;
    op_b       = '0;
    repeat (2) step();
    start = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", {a_gt_b, a_lt_b, a_eq_b}, 0);
    check("rst_cmp", {cmp_a, cmp_b}, 0);
    step();
    rst   = 1'b0;
    start = 1'b0;
    step();

    // Equal operands: all four nibbles visited, then hold of a_eq_b.
    issue(16'h1234, 16'h1234, 1'b0, t0, k);
    step();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("eq_nib_a", cmp_a, i);
      check("eq_nib_b", cmp_b, i);
      step();
    end
    step();
    @(negedge clk);
    check("eq_busy_low", busy, 0);
    check("eq_hold", a_eq_b, 1);

    // Decided on the first nibble.
    issue(16'h8000, 16'h7FFF, 1'b0, t0, k);
    step();
    start = 1'b0;
    @(negedge clk);
    check("gt_nib1", {cmp_a, cmp_b}, 8'h87);
    step();
    @(negedge clk);
    check("gt_no_nib2", (cmp_b == 4'hF), 0);
    repeat (2) step();

    // Decided on the third nibble.
    issue(16'hAB10, 16'hAB2F, 1'b0, t0, k);
    step();
    start = 1'b0;
    repeat (5) step();

    // Start pulses and operand change while running are ignored.
    issue(16'hAB10, 16'hAB2F, 1'b0, t0, k);
    step();
    op_a  = 16'hFFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();

    // Reset mid-compare aborts without a done pulse.
    issue(16'h1234, 16'h1234, 1'b0, t0, k);
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_res", {a_gt_b, a_lt_b, a_eq_b}, 0);
    check("abort_cmp", {cmp_a, cmp_b}, 0);
    issue(16'h00FF, 16'h0100, 1'b0, t0, k);
    step();
    start = 1'b0;
    repeat (5) step();

    // Inconsistent comparator flags: gt wins.
    force_both = 1'b1;
    issue(16'h5555, 16'h5555, 1'b1, t0, k);
    step();
    start = 1'b0;
    step();
    step();
    force_both = 1'b0;
    step();

    // Start held high: back-to-back compares at NIBBLES+2 spacing or less.
    for (int n = 0; n < 24; n++) begin
      ra = 16'($urandom);
      rb = (n % 5 == 0) ? ra : 16'($urandom);
      if (n % 7 == 3) rb = {ra[15:4], 4'($urandom)};
      issue(ra, rb, 1'b0, t0, k);
      repeat (k + 1) step();
    end
    start = 1'b0;
    repeat (N + 4) step();

    @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
